alu_cmd_driver: RTL

- Initiator-side driver for the team's registered ALU (inputs A, B, opcode; registered outputs result, carryout, overflow, zero; one-cycle latency).
- Accepts one operation at a time over a valid/ready command port and drives the ALU operand and opcode inputs.
- Waits out the ALU register stage, captures result and flags, and returns them with a tag over a valid/ready response port.
- Keeps saturating counters for completed operations and overflowing operations.

---
 rtl/alu_cmd_driver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver
// Brief    : Initiator-side driver for a registered (1-cycle) ALU. Accepts one
//            command over valid/ready, drives the ALU, captures result/flags
//            and returns them with the caller tag over valid/ready. Keeps
//            saturating counters of completed and overflowing operations.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
  parameter int NUMBITS = 32,
  parameter int TAGBITS = 4,
  parameter int CNTBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  // command port
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_opcode,
  input  logic [NUMBITS-1:0] cmd_a,
  input  logic [NUMBITS-1:0] cmd_b,
  input  logic [TAGBITS-1:0] cmd_tag,
  // ALU side
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  // response port
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [NUMBITS-1:0] rsp_result,
  output logic               rsp_carryout,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic [TAGBITS-1:0] rsp_tag,
  // statistics
  input  logic               stat_clear,
  output logic [CNTBITS-1:0] op_count,
  output logic [CNTBITS-1:0] ovf_count
);

  localparam logic [CNTBITS-1:0] CNT_MAX = '1;
  localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUMBITS-1:0]   alu_a_q, alu_a_d;
  logic [NUMBITS-1:0]   alu_b_q, alu_b_d;
  logic [2:0]           alu_op_q, alu_op_d;
  logic [TAGBITS-1:0]   tag_q, tag_d;
  logic [NUMBITS-1:0]   rsp_result_q, rsp_result_d;
  logic                 rsp_carry_q, rsp_carry_d;
  logic                 rsp_ovf_q, rsp_ovf_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic [TAGBITS-1:0]   rsp_tag_q, rsp_tag_d;
  logic [CNTBITS-1:0]   op_cnt_q, op_cnt_d;
  logic [CNTBITS-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic                 rsp_fire;

  // Response handshake: only meaningful while a response is presented.
  assign rsp_fire = (state_q == ST_RESP) && rsp_ready;

  // Next-state, operand/response capture and counter update logic.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    tag_d        = tag_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_tag_d    = rsp_tag_q;
    op_cnt_d     = op_cnt_q;
    ovf_cnt_d    = ovf_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // The ALU inputs double as the command register so they stay
        // stable (no return to zero) between operations.
        if (cmd_valid) begin
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_opcode;
          tag_d    = cmd_tag;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WAIT;
      ST_WAIT: begin
        // ALU register stage has produced its outputs; copy them verbatim.
        rsp_result_d = alu_result;
        rsp_carry_d  = alu_carryout;
        rsp_ovf_d    = alu_overflow;
        rsp_zero_d   = alu_zero;
        rsp_tag_d    = tag_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear wins over a coincident increment.
    if (stat_clear) begin
      op_cnt_d  = '0;
      ovf_cnt_d = '0;
    end else if (rsp_fire) begin
      if (op_cnt_q != CNT_MAX) begin
        op_cnt_d = op_cnt_q + CNT_ONE;
      end
      if (rsp_ovf_q && (ovf_cnt_q != CNT_MAX)) begin
        ovf_cnt_d = ovf_cnt_q + CNT_ONE;
      end
    end
  end

  // State, datapath and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
      op_cnt_q     <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tag_q        <= tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_tag_q    <= rsp_tag_d;
      op_cnt_q     <= op_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carryout = rsp_carry_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_tag      = rsp_tag_q;
  assign op_count     = op_cnt_q;
  assign ovf_count    = ovf_cnt_q;

endmodule
`default_nettype wire
